// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display driver.
// Holds the conversion FSM state type, digit count, conversion step count and
// the active-low 7-segment patterns (bit0 = segment a) with a lookup helper.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam int NUM_DIGITS  = 6;
  localparam int CONV_CYCLES = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports: i_bcd  - 4-bit BCD digit (10..15 decode to blank)
//        i_dash - force the dash pattern (segment g only)
//        o_seg  - segments a..g, active-low, bit0 = a
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) o_seg = SEG_DASH;
    else        o_seg = bcd_to_seg(i_bcd);
  end

endmodule

// File: rtl/clock_display_driver.sv
// Clock display driver: converts binary hh:mm:ss samples to BCD with a short
// multi-cycle FSM and scans them onto a 6-digit multiplexed 7-segment display.
// Ports: clk, reset_n (async, active-low), time_valid strobe with sec/min/hr,
//        busy (conversion running), range_err (one-cycle pulse at commit),
//        an (active-low one-hot digit enable, bit0 = seconds units),
//        seg (active-low a..g), dp (active-low decimal point).
// Build option: define COLON_BLINK_EN to blink dp on digits 2 and 4, toggling
// at every commit; without it dp is constant high.
//
// state  | meaning
// IDLE   | waiting for time_valid
// CONV   | six parallel double-dabble-style subtract-ten steps
// COMMIT | copy working BCD to display registers, maybe start pending sample
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 6000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       time_valid,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic       busy,
  output logic       range_err,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);

  state_t          r_state, w_state_nxt;
  logic            w_load, w_use_pend, w_commit;
  logic [2:0]      r_conv_cnt;
  logic            r_pend_vld;
  logic [5:0]      r_pend_sec, r_pend_min;
  logic [4:0]      r_pend_hr;
  logic [5:0]      w_src_sec, w_src_min;
  logic [4:0]      w_src_hr;
  logic [2:0][5:0] r_units;
  logic [2:0][2:0] r_tens;
  logic [2:0]      r_dash;
  logic [NUM_DIGITS-1:0][3:0] r_disp;
  logic [2:0]      r_disp_dash;
  logic            r_range_err;
  logic [PW-1:0]   r_presc;
  logic [2:0]      r_idx;
  logic [3:0]      w_digit;
  logic            w_digit_dash;
  logic [6:0]      w_seg;
  logic [5:0]      r_an;
  logic [6:0]      r_seg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // A strobe arriving in the COMMIT cycle is newer than the pending copy,
  // so it is captured directly and the pending copy is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_use_pend  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (time_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (r_conv_cnt == 3'd0) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit = 1'b1;
        if (time_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CONV;
        end else if (r_pend_vld) begin
          w_load      = 1'b1;
          w_use_pend  = 1'b1;
          w_state_nxt = CONV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign range_err = r_range_err;
  assign w_src_sec = w_use_pend ? r_pend_sec : sec;
  assign w_src_min = w_use_pend ? r_pend_min : min;
  assign w_src_hr  = w_use_pend ? r_pend_hr  : hr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_vld <= 1'b0;
      r_pend_sec <= '0;
      r_pend_min <= '0;
      r_pend_hr  <= '0;
    end else if (w_load) begin
      r_pend_vld <= 1'b0;
    end else if (time_valid && busy) begin
      r_pend_vld <= 1'b1;
      r_pend_sec <= sec;
      r_pend_min <= min;
      r_pend_hr  <= hr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 r_conv_cnt <= '0;
    else if (w_load)                              r_conv_cnt <= 3'(CONV_CYCLES - 1);
    else if (r_state == CONV && r_conv_cnt != 0)  r_conv_cnt <= r_conv_cnt - 3'd1;
  end

  // Field order in the working arrays: 0 = sec, 1 = min, 2 = hr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_units <= '0;
      r_tens  <= '0;
      r_dash  <= '0;
    end else if (w_load) begin
      r_units[0] <= w_src_sec;
      r_units[1] <= w_src_min;
      r_units[2] <= {1'b0, w_src_hr};
      r_tens     <= '0;
      r_dash     <= {w_src_hr > 5'd23, w_src_min > 6'd59, w_src_sec > 6'd59};
    end else if (r_state == CONV) begin
      for (int f = 0; f < 3; f++) begin
        if (r_units[f] >= 6'd10) begin
          r_units[f] <= r_units[f] - 6'd10;
          r_tens[f]  <= r_tens[f] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp      <= '0;
      r_disp_dash <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_range_err <= 1'b0;
      if (w_commit) begin
        for (int f = 0; f < 3; f++) begin
          r_disp[2*f]   <= r_units[f][3:0];
          r_disp[2*f+1] <= {1'b0, r_tens[f]};
        end
        r_disp_dash <= r_dash;
        r_range_err <= |r_dash;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_digit      = '0;
    w_digit_dash = 1'b0;
    case (r_idx)
      3'd0: begin w_digit = r_disp[0]; w_digit_dash = r_disp_dash[0]; end
      3'd1: begin w_digit = r_disp[1]; w_digit_dash = r_disp_dash[0]; end
      3'd2: begin w_digit = r_disp[2]; w_digit_dash = r_disp_dash[1]; end
      3'd3: begin w_digit = r_disp[3]; w_digit_dash = r_disp_dash[1]; end
      3'd4: begin w_digit = r_disp[4]; w_digit_dash = r_disp_dash[2]; end
      3'd5: begin w_digit = r_disp[5]; w_digit_dash = r_disp_dash[2]; end
      default: begin w_digit = '0; w_digit_dash = 1'b0; end
    endcase
  end

  seg7_decode u_dec (
    .i_bcd  (w_digit),
    .i_dash (w_digit_dash),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= 6'b111111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(6'b000001 << r_idx);
      r_seg <= w_seg;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

`ifdef COLON_BLINK_EN
  logic r_blink;
  logic r_dp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= 1'b0;
      r_dp    <= 1'b1;
    end else begin
      if (w_commit) r_blink <= ~r_blink;
      r_dp <= ~(r_blink && (r_idx == 3'd2 || r_idx == 3'd4));
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver: directed and random time
// samples, reference display computed arithmetically, scoreboard queue popped
// by a monitor whenever a conversion finishes (busy falls).
module tb_clock_display_driver;

  localparam int CLK_HZ  = 12;
  localparam int SCAN_HZ = 3;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       time_valid = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr = '0;
  logic       busy, range_err, dp;
  logic [5:0] an;
  logic [6:0] seg;

  clock_display_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .time_valid (time_valid),
    .sec        (sec),
    .min        (min),
    .hr         (hr),
    .busy       (busy),
    .range_err  (range_err),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0][6:0] segs;
    logic [5:0]      dps;
    logic            rerr;
  } exp_t;

  exp_t q[$];
  bit   mon_busy = 1'b0;
  bit   exp_blink = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int s, input int m, input int h, input bit blink);
    exp_t e;
    int   v [3];
    int   lim [3];
    v = '{s, m, h};
    lim = '{59, 59, 23};
    e.rerr = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (v[f] > lim[f]) begin
        e.segs[2*f]   = 7'h3F;
        e.segs[2*f+1] = 7'h3F;
        e.rerr = 1'b1;
      end else begin
        e.segs[2*f]   = SEG_TAB[v[f] % 10];
        e.segs[2*f+1] = SEG_TAB[v[f] / 10];
      end
    end
`ifdef COLON_BLINK_EN
    e.dps = blink ? 6'b101011 : 6'b111111;
`else
    e.dps = 6'b111111;
`endif
    return e;
  endfunction

  // Observe a full scan rotation, recording what each digit slot shows.
  task automatic scan(output logic [5:0][6:0] s, output logic [5:0] d, output logic [5:0] seen);
    s = '0;
    d = '0;
    seen = '0;
    for (int k = 0; k < 6 * DIV + 2; k++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (an == ~(6'b000001 << i)) begin
          s[i] = seg;
          d[i] = dp;
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin : monitor
    bit pb;
    exp_t e;
    logic [5:0][6:0] s;
    logic [5:0] d, seen;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pb = 1'b0;
      end else if (pb && !busy) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_commit actual=commit required=none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("range_err_at_commit", range_err, e.rerr);
          scan(s, d, seen);
          chk("range_err_width", range_err, 1'b0);
          chk("digits_seen", seen, 6'h3F);
          for (int i = 0; i < 6; i++) begin
            chk($sformatf("seg_digit%0d", i), s[i], e.segs[i]);
            chk($sformatf("dp_digit%0d", i), d[i], e.dps[i]);
          end
        end
        pb = busy;
        mon_busy = 1'b0;
      end else begin
        pb = busy;
      end
    end
  end

  task automatic issue(input int s, input int m, input int h);
    @(negedge clk);
    sec = 6'(s);
    min = 6'(m);
    hr = 5'(h);
    time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
  endtask

  task automatic busy_len(output int c);
    c = 0;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (q.size() == 0 && !mon_busy) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_commit actual=timeout required=commit at %0t", $time);
    q.delete();
  endtask

  task automatic run_vec(input int s, input int m, input int h);
    int c;
    exp_blink = ~exp_blink;
    q.push_back(model(s, m, h, exp_blink));
    issue(s, m, h);
    busy_len(c);
    chk("busy_len", c, 7);
    wait_done();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [5:0] exp_an, nxt;
    int hold, c, rose;
    logic [5:0][6:0] s;
    logic [5:0] d, seen;

    repeat (3) @(negedge clk);
    chk("rst_an", an, 6'h3F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_range_err", range_err, 1'b0);
    reset_n = 1'b1;

    exp_an = 6'h3E;
    hold = 0;
    for (int k = 0; k < 6 * DIV + 2; k++) begin
      @(negedge clk);
      if (an == exp_an) begin
        hold++;
      end else begin
        nxt = {exp_an[4:0], exp_an[5]};
        chk("an_hold", hold, DIV);
        chk("an_next", an, nxt);
        chk("idle_seg_zero", seg, 7'h40);
        exp_an = nxt;
        hold = 1;
      end
    end

    run_vec(59, 59, 23);
    run_vec(60, 5, 7);

    // Overlap: two strobes during the first conversion, only the last survives.
    exp_blink = ~exp_blink;
    exp_blink = ~exp_blink;
    q.push_back(model(11, 30, 12, exp_blink));
    issue(5, 30, 12);
    fork
      begin
        @(negedge clk);
        sec = 6'd10; time_valid = 1'b1;
        @(negedge clk);
        time_valid = 1'b0;
        @(negedge clk);
        sec = 6'd11; time_valid = 1'b1;
        @(negedge clk);
        time_valid = 1'b0;
      end
      busy_len(c);
    join
    chk("busy_len_back_to_back", c, 14);
    wait_done();

    for (int n = 0; n < 20; n++) begin
      int rs, rm, rh;
      rs = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      rm = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
      rh = ($urandom_range(0, 4) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      run_vec(rs, rm, rh);
    end

    // Reset in the middle of a conversion: nothing may be committed.
    issue(1, 2, 3);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_an", an, 6'h3F);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_range_err", range_err, 1'b0);
    exp_blink = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rose = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || range_err) rose = 1;
    end
    chk("midrst_no_commit", rose, 0);
    scan(s, d, seen);
    chk("midrst_seen", seen, 6'h3F);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst_seg%0d", i), s[i], 7'h40);
      chk($sformatf("midrst_dp%0d", i), d[i], 1'b1);
    end

    run_vec(7, 8, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
- Downstream stage of the hh:mm:ss counter.
- Takes binary hr/min/sec samples, converts them to BCD with a small multi-cycle FSM, and drives a 6-digit multiplexed 7-segment display (active-low segments and anodes).
- Decouples counter updates from the display scan so the digits never show a half-updated time.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SCAN_HZ, 6000, digit-advance rate in Hz; CLK_HZ/SCAN_HZ must be an integer >= 2. Prescaler width is $clog2(CLK_HZ/SCAN_HZ).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- time_valid  in  1  one-cycle strobe; sec/min/hr are valid this cycle
- sec  in  6  seconds, binary, legal 0..59
- min  in  6  minutes, binary, legal 0..59
- hr  in  5  hours, binary, legal 0..23
- busy  out  1  conversion in progress
- range_err  out  1  one-cycle pulse at COMMIT if any field was out of range
- an  out  6  digit enables, active-low, one-hot; bit0 = seconds units, bit5 = hours tens
- seg  out  7  segments a..g, active-low, bit0 = a
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, while reset_n=0) forces:
  - an=6'b111111, seg=7'h7F, dp=1, busy=0, range_err=0
  - display BCD registers all 0, digit index 0, prescaler 0
  - pending flag cleared, FSM in IDLE
- Reset mid-conversion discards the in-flight sample and any pending sample.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: on time_valid=1, capture sec/min/hr into working registers at edge E0, then go to CONV. busy=1 from E0.
  - CONV: runs exactly 6 cycles (E1..E6), controlled by a 3-bit counter. Each cycle, in parallel per field, if units >= 10 then units -= 10 and tens += 1.
  - COMMIT: at E7, write working BCD to the display registers and pulse range_err if flagged. busy falls at E7. Next state is CONV (with pending capture) if the pending flag is set, otherwise IDLE.
- Fixed latency: display registers change 7 cycles after the capture edge.
- Range check at capture: sec>59, min>59 or hr>23 marks that field's two digits as DASH (seg = g only, 7'h3F). range_err asserts for one cycle at COMMIT.
- time_valid while busy: sample stored in a one-deep pending register; later strobes overwrite it (last wins). When pending is taken at COMMIT, the new capture occurs on that same E7 edge.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1. On terminal count, digit index advances 0→1→...→5→0 (wrap).
  - an and seg are registered on the same edge and change together. One cycle of latency from index change.
  - No blanking between digits.
- Display registers never change mid-digit except at COMMIT. A COMMIT is visible on the next registered seg update.

Optional Feature:
COLON_BLINK_EN
- Defined: a blink bit toggles at every COMMIT. When blink=1, dp=0 (lit) on digits 2 and 4 (min units, hr units). dp=1 elsewhere. Reset clears blink to 0.
- Undefined: dp is tied to 1 permanently and no blink register exists.

Decomposition:
- Package clock_disp_pkg:
  - FSM state enum (IDLE, CONV, COMMIT)
  - NUM_DIGITS=6
  - 7-segment constants for 0-9, DASH=7'h3F, BLANK=7'h7F
  - CONV_CYCLES=6
- Sub-module seg7_decode: combinational, 4-bit BCD plus a dash flag in, 7-bit active-low segment pattern out. Codes 10..15 map to BLANK.

Test Plan:
- Reset release with no time_valid → an cycles 111110,111101,...,011111 every CLK_HZ/SCAN_HZ clocks; seg=7'h40 ("0") on every digit.
- time_valid with hr=23, min=59, sec=59 → busy high for 7 cycles; then digits (5..0) show 2,3,5,9,5,9 (seg 7'h24,7'h30,7'h12,7'h10,7'h12,7'h10); range_err stays 0.
- time_valid with sec=60, min=5, hr=7 → range_err pulses once at COMMIT; digits 1..0 show DASH (7'h3F); other digits show 0,7,0,5.
- Two time_valid strobes 2 and 4 cycles after the first capture (sec=10, then sec=11) → the sec=10 sample is dropped; a second conversion starts at E7; final seconds display shows 1,1; busy continuous for 14 cycles.
- reset_n low at E3 of a conversion → all outputs return to reset values immediately; after release the display shows 000000 and no COMMIT occurs.
- With COLON_BLINK_EN: three updates → dp lit on digits 2/4 after the 1st and 3rd COMMIT, unlit after the 2nd. Without the macro: dp=1 throughout.
